// File: rtl/alu_pkg.sv
// Shared definitions for the mtm_Alu response path.
// Contents: frame geometry, bit-level FSM state type, flag/err bit indices,
// and the CRC3 generator polynomial with a one-bit update helper.
package alu_pkg;

  localparam int unsigned FRAME_BITS    = 11; // start + type + 8 payload + stop
  localparam int unsigned PAYLOAD_BITS  = 8;
  localparam int unsigned DATA_BYTES    = 4;
  // Leading ctl payload bits that belong to the CRC message ({1'b0, flags}).
  localparam int unsigned CTL_CRC_BITS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    PAYLOAD,
    STOP
  } bit_state_t;

  // Bit positions in the flags output: {carry, overflow, zero, negative}.
  localparam int unsigned FLAG_CARRY    = 3;
  localparam int unsigned FLAG_OVERFLOW = 2;
  localparam int unsigned FLAG_ZERO     = 1;
  localparam int unsigned FLAG_NEGATIVE = 0;

  // Bit positions in the err_flags output: {ERR_DATA, ERR_CRC, ERR_OP}.
  localparam int unsigned ERR_DATA      = 2;
  localparam int unsigned ERR_CRC       = 1;
  localparam int unsigned ERR_OP        = 0;

  // x^3 + x + 1, with the implicit x^3 term dropped.
  localparam logic [2:0] CRC3_POLY = 3'b011;

  function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic b);
    logic fb;
    fb = crc[2] ^ b;
    return {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
  endfunction

endpackage

// File: rtl/alu_crc3.sv
// Serial CRC3 engine, one message bit per enabled cycle, MSB first.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : reset the remainder to zero (wins over en)
//   en         : absorb bit_in this cycle
//   bit_in     : message bit
//   crc        : running remainder
module alu_crc3
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [2:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc3_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/alu_resp_decoder.sv
// Decodes mtm_Alu serial responses: four data frames (C, MSB byte first)
// followed by a ctl frame, or a single error ctl frame.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   sout       : serial response line, idles high
//   resp_valid : one-cycle pulse when a response or an abort completes
//   resp_err   : 1 = error packet, 0 = data packet
//   result     : decoded C
//   flags      : {carry, overflow, zero, negative}
//   err_flags  : {ERR_DATA, ERR_CRC, ERR_OP}
//   crc_ok     : CRC3 match (data) or parity/copy match (error)
//   proto_err  : framing, sequence or idle-timeout violation
// Result-side outputs change only together with resp_valid.
module alu_resp_decoder
  import alu_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  err_flags,
  output logic        crc_ok,
  output logic        proto_err
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  bit_state_t        state;
  logic [2:0]        bit_cnt;
  logic [2:0]        byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              prev_sout;
  logic              is_ctl;
  logic [7:0]        sr;
  logic [31:0]       acc;
  logic [2:0]        crc;

  logic start, timeout, stop_ok, data_frame, pub_data, pub_err, abort;
  logic crc_clr, crc_en;

  // prev_sout resets low so a line already low at reset release is not
  // mistaken for a start bit; a real start needs a high-to-low transition.
  always_comb begin
    start      = 1'b0;
    timeout    = 1'b0;
    stop_ok    = 1'b0;
    data_frame = 1'b0;
    pub_data   = 1'b0;
    pub_err    = 1'b0;
    abort      = 1'b0;
    start      = (state == IDLE) && !sout && prev_sout;
    timeout    = (state == IDLE) && !start && (byte_cnt != 3'd0) &&
                 (idle_cnt == IDLE_W'(IDLE_TIMEOUT));
    stop_ok    = (state == STOP) && sout;
    data_frame = stop_ok && !is_ctl && (byte_cnt < 3'(DATA_BYTES));
    pub_data   = stop_ok && is_ctl && !sr[7] && (byte_cnt == 3'(DATA_BYTES));
    pub_err    = stop_ok && is_ctl && sr[7] && (byte_cnt == 3'd0);
    abort      = timeout ||
                 ((state == STOP) && !(data_frame || pub_data || pub_err));
  end

  // The CRC message {result, 1'b0, flags} is exactly the 32 data payload
  // bits followed by the first five ctl payload bits.
  always_comb begin
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_clr = start && (byte_cnt == 3'd0);
    crc_en  = (state == PAYLOAD) &&
              (!is_ctl || (bit_cnt < 3'(CTL_CRC_BITS)));
  end

  alu_crc3 u_crc3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (sout),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      prev_sout  <= 1'b0;
      is_ctl     <= 1'b0;
      sr         <= '0;
      acc        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      result     <= '0;
      flags      <= '0;
      err_flags  <= '0;
      crc_ok     <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      prev_sout  <= sout;
      resp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= TYPE;
            idle_cnt <= '0;
          end else if (byte_cnt != 3'd0 && !timeout) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        TYPE: begin
          is_ctl  <= sout;
          bit_cnt <= '0;
          state   <= PAYLOAD;
        end
        PAYLOAD: begin
          sr      <= {sr[6:0], sout};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(PAYLOAD_BITS - 1)) begin
            state <= STOP;
          end
        end
        STOP: begin
          state <= IDLE;
          if (data_frame) begin
            acc      <= {acc[23:0], sr};
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (pub_data) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        proto_err  <= 1'b0;
        result     <= acc;
        flags      <= sr[6:3];
        err_flags  <= '0;
        crc_ok     <= (crc == sr[2:0]);
        byte_cnt   <= '0;
        idle_cnt   <= '0;
      end else if (pub_err) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b1;
        proto_err  <= 1'b0;
        result     <= '0;
        flags      <= '0;
        err_flags  <= sr[6:4];
        crc_ok     <= !(^sr) && (sr[6:4] == sr[3:1]);
        byte_cnt   <= '0;
        idle_cnt   <= '0;
      end else if (abort) begin
        state      <= IDLE;
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        proto_err  <= 1'b1;
        result     <= '0;
        flags      <= '0;
        err_flags  <= '0;
        crc_ok     <= 1'b0;
        byte_cnt   <= '0;
        idle_cnt   <= '0;
      end
    end
  end

endmodule
